// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port 16-bit data memory.
// Round-robin or fixed-priority grant, one access per cycle, registered responses.
module dmem_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int MEM_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  output logic        m1_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  logic        last_winner;
  logic [7:0]  wait0, wait1;
  logic [15:0] addr_q, wdata_q;
  logic        g0, g1, any_gnt;
  logic        win_we, bad;
  logic [15:0] win_addr, win_wdata, rsp;
  logic        starve0, starve1;

  assign starve0 = wait0 >= 8'd4;
  assign starve1 = wait1 >= 8'd4;

  // Starvation guard outranks both policies; a tie falls back to the policy.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        if (starve0 != starve1) begin
          g0 = starve0;
          g1 = starve1;
        end else if (FIXED_PRIO != 0) begin
          g0 = 1'b1;
        end else if (last_winner) begin
          g0 = 1'b1;
        end else begin
          g1 = 1'b1;
        end
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign any_gnt   = g0 | g1;
  assign win_addr  = g1 ? m1_addr  : m0_addr;
  assign win_wdata = g1 ? m1_wdata : m0_wdata;
  assign win_we    = g1 ? m1_we    : m0_we;
  assign bad       = win_addr[0] || ({17'd0, win_addr[15:1]} >= 32'(MEM_WORDS));
  assign rsp       = (bad || win_we) ? 16'h0000 : mem_rdata;

  // Idle cycles keep presenting the last winner's address and data.
  assign mem_addr  = any_gnt ? win_addr  : addr_q;
  assign mem_wdata = any_gnt ? win_wdata : wdata_q;
  assign mem_we    = any_gnt & win_we & ~bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= 1'b1;
      wait0       <= 8'd0;
      wait1       <= 8'd0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= 16'h0000;
      m1_rdata    <= 16'h0000;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
    end else begin
      m0_rvalid <= g0;
      m1_rvalid <= g1;
      if (any_gnt) begin
        last_winner <= g1;
        addr_q      <= win_addr;
        wdata_q     <= win_wdata;
      end
      if (g0) begin
        m0_rdata <= rsp;
        m0_err   <= bad;
      end
      if (g1) begin
        m1_rdata <= rsp;
        m1_err   <= bad;
      end
      wait0 <= (!m0_req || g0) ? 8'd0 : ((wait0 == 8'd255) ? wait0 : wait0 + 8'd1);
      wait1 <= (!m1_req || g1) ? 8'd0 : ((wait1 == 8'd255) ? wait1 : wait1 + 8'd1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model (expected memory image, per-requester wait ages).
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req = 2'b00, we = 2'b00;
  logic [1:0][15:0] addr = '0, wdata = '0;
  wire  [1:0]       gnt, rvalid, err;
  wire  [1:0][15:0] rdata;
  wire  [15:0]      mem_addr, mem_wdata, mem_rdata;
  wire              mem_we;
  logic [15:0]      mem [0:2047];

  dmem_arbiter #(.FIXED_PRIO(0), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) if (mem_we) mem[mem_addr[11:1]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[11:1]];

  // Fixed-priority instance, used only for the starvation-guard pattern.
  logic [1:0]       p_req = 2'b00;
  logic [1:0][15:0] p_addr;
  wire  [1:0]       p_gnt, p_rvalid, p_err;
  wire  [1:0][15:0] p_rdata;
  wire  [15:0]      p_mem_addr, p_mem_wdata, p_mem_rdata;
  wire              p_mem_we;
  assign p_addr[0] = 16'h0020;
  assign p_addr[1] = 16'h0040;
  assign p_mem_rdata = p_mem_addr ^ 16'hA5A5;

  dmem_arbiter #(.FIXED_PRIO(1), .MEM_WORDS(1024)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(p_req[0]), .m0_we(1'b0), .m0_addr(p_addr[0]), .m0_wdata(16'h0000),
    .m0_gnt(p_gnt[0]), .m0_rvalid(p_rvalid[0]), .m0_rdata(p_rdata[0]), .m0_err(p_err[0]),
    .m1_req(p_req[1]), .m1_we(1'b0), .m1_addr(p_addr[1]), .m1_wdata(16'h0000),
    .m1_gnt(p_gnt[1]), .m1_rvalid(p_rvalid[1]), .m1_rdata(p_rdata[1]), .m1_err(p_err[1]),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we), .mem_rdata(p_mem_rdata)
  );

  int passes = 0, total = 0;

  // Reference model state.
  logic [15:0] rmem [0:1023];
  logic [1:0]  pend = 2'b00;
  int          wt [2];
  int          rl;
  logic [15:0] exp_rd [2];
  logic        exp_er [2];
  logic [15:0] last_a, last_d;
  logic [1:0]  got_gnt;
  logic        got_we;
  bit          allow_cancel = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input int m, input logic w, input logic [15:0] a, input logic [15:0] d);
    pend[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
  endtask

  task automatic model_reset();
    rl = 1; wt[0] = 0; wt[1] = 0;
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    last_a = 16'h0; last_d = 16'h0;
  endtask

  // Winner by the arbitration rules: aged requester first, else alternate.
  function automatic int pick();
    bit s0, s1;
    if (pend == 2'b11) begin
      s0 = wt[0] >= 4;
      s1 = wt[1] >= 4;
      if (s0 && !s1) return 0;
      if (s1 && !s0) return 1;
      return (rl == 1) ? 0 : 1;
    end
    if (pend[0]) return 0;
    if (pend[1]) return 1;
    return -1;
  endfunction

  task automatic step();
    int w;
    bit bad;
    logic [1:0] eg;
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      if (allow_cancel && pend[m] && wt[m] > 0 && $urandom_range(0, 7) == 0) pend[m] = 1'b0;
    req = pend;
    #1;
    w = pick();
    eg = 2'b00;
    if (w >= 0) eg[w] = 1'b1;
    got_gnt = gnt;
    got_we = mem_we;
    chk("gnt", 16'(gnt), 16'(eg));
    if (w >= 0) begin
      bad = addr[w][0] || (addr[w][15:1] >= 15'd1024);
      chk("mem_addr", mem_addr, addr[w]);
      chk("mem_wdata", mem_wdata, wdata[w]);
      chk("mem_we", 16'(mem_we), 16'(we[w] && !bad));
      last_a = addr[w];
      last_d = wdata[w];
      exp_er[w] = bad;
      exp_rd[w] = (bad || we[w]) ? 16'h0 : rmem[addr[w][10:1]];
      if (!bad && we[w]) rmem[addr[w][10:1]] = wdata[w];
    end else begin
      chk("idle_mem_we", 16'(mem_we), 16'h0);
      chk("idle_mem_addr", mem_addr, last_a);
      chk("idle_mem_wdata", mem_wdata, last_d);
    end
    for (int m = 0; m < 2; m++)
      wt[m] = (pend[m] && w != m) ? ((wt[m] < 255) ? wt[m] + 1 : 255) : 0;
    if (w >= 0) begin
      rl = w;
      pend[w] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rvalid", 16'(rvalid), 16'(eg));
    for (int m = 0; m < 2; m++) begin
      chk("rdata", rdata[m], exp_rd[m]);
      chk("err", 16'(err[m]), 16'(exp_er[m]));
    end
  endtask

  initial begin
    logic [1:0] eg;
    int pw;
    int r;
    logic [15:0] a;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    for (int i = 0; i < 1024; i++) rmem[i] = 16'h0;
    model_reset();

    // Reset state, including requests held high during reset.
    #1 rst_n = 1'b0;
    req = 2'b11;
    #2;
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_rvalid", 16'(rvalid), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_rdata0", rdata[0], 16'h0);
    chk("rst_rdata1", rdata[1], 16'h0);
    chk("rst_p_rvalid", 16'(p_rvalid), 16'h0);
    req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Fixed priority: four m0 grants, then one m1 grant from the aging guard.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      p_req = 2'b11;
      #1;
      eg = (k % 5 == 4) ? 2'b10 : 2'b01;
      pw = (k % 5 == 4) ? 1 : 0;
      chk("fp_gnt", 16'(p_gnt), 16'(eg));
      chk("fp_mem_we", 16'(p_mem_we), 16'h0);
      chk("fp_mem_wdata", p_mem_wdata, 16'h0);
      @(posedge clk);
      #1;
      chk("fp_rvalid", 16'(p_rvalid), 16'(eg));
      chk("fp_rdata", p_rdata[pw], p_addr[pw] ^ 16'hA5A5);
      chk("fp_err", 16'(p_err[pw]), 16'h0);
    end
    @(negedge clk) p_req = 2'b00;

    // Round-robin alternation under continuous contention.
    for (int k = 0; k < 6; k++) begin
      if (!pend[0]) issue(0, 1'b0, 16'h0002, 16'h0);
      if (!pend[1]) issue(1, 1'b0, 16'h0004, 16'h0);
      step();
      chk("rr_alt", 16'(got_gnt), (k % 2 == 0) ? 16'h0001 : 16'h0002);
    end

    // Write then read back.
    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    step();
    chk("wr_we", 16'(got_we), 16'h1);
    issue(0, 1'b0, 16'h0010, 16'h0);
    step();
    chk("rd_beef", rdata[0], 16'hBEEF);
    chk("rd_err", 16'(err[0]), 16'h0);

    // Misaligned and out-of-range writes.
    issue(1, 1'b1, 16'h0011, 16'h1111);
    step();
    chk("mis_we", 16'(got_we), 16'h0);
    chk("mis_err", 16'(err[1]), 16'h1);
    chk("mis_rdata", rdata[1], 16'h0);
    issue(1, 1'b1, 16'h0800, 16'h2222);
    step();
    chk("oor_we", 16'(got_we), 16'h0);
    chk("oor_err", 16'(err[1]), 16'h1);
    chk("oor_rdata", rdata[1], 16'h0);

    // Random traffic with occasional cancellation before grant.
    allow_cancel = 1;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 3) != 0) begin
          r = $urandom_range(0, 9);
          a = 16'($urandom_range(0, 7)) << 1;
          if (r == 0) a[0] = 1'b1;
          else if (r == 1) a = 16'($urandom_range(2048, 65534)) & 16'hFFFE;
          issue(m, 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
      step();
    end
    allow_cancel = 0;
    pend = 2'b00;
    step();

    // Reset while a granted read is in flight.
    issue(0, 1'b0, 16'h0004, 16'h0);
    @(negedge clk);
    req = pend;
    #1;
    chk("rst_mid_gnt", 16'(gnt), 16'h0001);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt_low", 16'(gnt), 16'h0);
    chk("rst_mid_mem_we", 16'(mem_we), 16'h0);
    @(posedge clk);
    #1;
    chk("rst_mid_rvalid", 16'(rvalid), 16'h0);
    chk("rst_mid_err", 16'(err), 16'h0);
    chk("rst_mid_rdata", rdata[0], 16'h0);
    chk("rst_mid_mem_addr", mem_addr, 16'h0);
    pend = 2'b00;
    req = 2'b00;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    issue(0, 1'b0, 16'h0006, 16'h0);
    issue(1, 1'b0, 16'h0008, 16'h0);
    step();
    chk("post_rst_m0", 16'(got_gnt), 16'h0001);
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have a single clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter FIXED_PRIO, default 0, SHALL select the policy: 0 = round-robin, 1 = m0 always wins.
REQ-003 Parameter MEM_WORDS, default 1024, SHALL be the number of 16-bit words in the data memory.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 m0_req, m1_req  input  1 each  requester asserts a pending access.
REQ-007 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-008 m0_addr, m1_addr  input  16 each  byte address.
REQ-009 m0_wdata, m1_wdata  input  16 each  write data.
REQ-010 m0_gnt, m1_gnt  output  1 each  combinational, access accepted this cycle.
REQ-011 m0_rvalid, m1_rvalid  output  1 each  registered response strobe.
REQ-012 m0_rdata, m1_rdata  output  16 each  registered read data.
REQ-013 m0_err, m1_err  output  1 each  registered error flag, qualified by rvalid.
REQ-014 mem_addr  output  16  byte address to the data memory; the memory uses bits [11:1].
REQ-015 mem_wdata  output  16  write data to the memory.
REQ-016 mem_we  output  1  write enable to the memory (synchronous write).
REQ-017 mem_rdata  input  16  combinational read data from the memory.

Function
REQ-018 At most one gnt SHALL be high per cycle; gnt SHALL only assert for a requester whose req is high in the same cycle.
REQ-019 Round-robin SHALL keep a 1-bit last_winner register; on contention, the requester not equal to last_winner SHALL win.
REQ-020 last_winner SHALL update on every cycle with any grant.
REQ-021 A lone requester SHALL be granted in the same cycle regardless of last_winner.
REQ-022 With FIXED_PRIO=1, m0 SHALL win all contention and last_winner SHALL be ignored.
REQ-023 In a grant cycle, mem_addr and mem_wdata SHALL carry the winner's addr and wdata.
REQ-024 In a grant cycle, mem_we SHALL equal winner_we AND NOT bad.
REQ-025 In idle cycles, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold the last winner's values.
REQ-026 An access is bad when addr[0]=1 (misaligned) or addr[15:1] >= MEM_WORDS (out of range).
REQ-027 A bad access SHALL still be granted, SHALL never write memory, and SHALL return err=1 with rdata=16'h0000.
REQ-028 Each grant SHALL produce exactly one rvalid pulse to the same requester on the next rising edge (latency 1), for reads and writes alike.
REQ-029 For a good read, rdata SHALL be mem_rdata sampled at the grant edge; for a write, rdata SHALL be 16'h0000.
REQ-030 rdata SHALL hold its value until that requester's next rvalid.
REQ-031 Throughput SHALL be one access per cycle; back-to-back grants to the same requester SHALL be allowed when the other requester is idle.
REQ-032 A read granted the cycle after a write to the same word SHALL return the newly written data.
REQ-033 A requester SHALL keep req, we, addr and wdata stable until it sees gnt; dropping req before gnt SHALL cancel the access without side effect.
REQ-034 A per-requester 8-bit wait counter SHALL count consecutive cycles with req high and gnt low, saturate at 255, and clear on grant.
REQ-035 A requester whose wait counter reaches 4 SHALL win the next contention regardless of last_winner or FIXED_PRIO (starvation guard).

Reset
REQ-036 While rst_n=0, all gnt, rvalid, err and mem_we SHALL be 0.
REQ-037 While rst_n=0, rdata, mem_addr and mem_wdata SHALL be 16'h0000; last_winner SHALL be 1 (so m0 wins the first contention) and wait counters SHALL be 0.
REQ-038 Reset asserted mid-access SHALL drop any pending rvalid and SHALL cause no memory write on later edges.

Verification
REQ-039 m0 writes 16'hBEEF at address 16'h0010, then reads it back -> m0_rvalid after each grant; the read returns rdata=16'hBEEF, err=0.
REQ-040 m0 and m1 request reads every cycle for 6 cycles -> grants alternate m0, m1, m0, m1, m0, m1, each rvalid follows its grant by one cycle.
REQ-041 m1 writes to address 16'h0011, then to address 16'h0800 -> both granted, mem_we=0 for both, m1_err=1, m1_rdata=16'h0000.
REQ-042 FIXED_PRIO=1 with both requesters continuously active -> m0 granted 4 cycles, then m1 granted once (starvation guard), then the pattern repeats.
REQ-043 rst_n pulled low on the edge after m0 is granted a read -> no m0_rvalid appears, all outputs are 0, and the next contention goes to m0.
